// File: rtl/gray_to_bin_tracker.sv
// Gray-code to binary converter with step/direction tracking, wrap-around position counter and saturating error count.
// Optional macro GRAY_SYNC_EN inserts a 2-flop input synchronizer ahead of the capture stage.
module gray_to_bin_tracker #(
    parameter int W    = 4,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [W-1:0]    g,
    input  logic            pos_clr,
    output logic [W-1:0]    b,
    output logic            b_valid,
    output logic            step_up,
    output logic            step_dn,
    output logic            err,
    output logic            dir,
    output logic [CNTW-1:0] pos,
    output logic [7:0]      err_cnt
);

    typedef enum logic {S_PRIME = 1'b0, S_TRACK = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [W-1:0]    w_g_cap;
    logic [W-1:0]    w_bin;
    logic [W-1:0]    r_p;
    logic            r_b_valid;
    logic            r_step_up;
    logic            r_step_dn;
    logic            r_err;
    logic            r_dir;
    logic [CNTW-1:0] r_pos;
    logic [7:0]      r_err_cnt;
    logic            w_step_up;
    logic            w_step_dn;
    logic            w_err;

`ifdef GRAY_SYNC_EN
    logic [W-1:0] r_sync1;
    logic [W-1:0] r_sync2;

    // Free-running synchronizer; en only gates the capture stage behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= g;
            r_sync2 <= r_sync1;
        end
    end

    assign w_g_cap = r_sync2;
`else
    assign w_g_cap = g;
`endif

    // Each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_conv
            assign w_bin[gi] = ^w_g_cap[W-1:gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_PRIME;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == S_PRIME && en) begin
            w_state_next = S_TRACK;
        end
    end

    always_comb begin
        w_step_up = 1'b0;
        w_step_dn = 1'b0;
        w_err     = 1'b0;
        if (en && r_state == S_TRACK && w_bin != r_p) begin
            if (w_bin == r_p + W'(1)) begin
                w_step_up = 1'b1;
            end else if (w_bin == r_p - W'(1)) begin
                w_step_dn = 1'b1;
            end else begin
                w_err = 1'b1;
            end
        end
    end

    // The last captured binary value doubles as the comparison reference p.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p       <= '0;
            r_b_valid <= 1'b0;
            r_step_up <= 1'b0;
            r_step_dn <= 1'b0;
            r_err     <= 1'b0;
            r_dir     <= 1'b0;
            r_pos     <= '0;
            r_err_cnt <= '0;
        end else begin
            r_step_up <= w_step_up;
            r_step_dn <= w_step_dn;
            r_err     <= w_err;
            if (en) begin
                r_p       <= w_bin;
                r_b_valid <= 1'b1;
            end
            if (w_step_up) begin
                r_dir <= 1'b1;
            end else if (w_step_dn) begin
                r_dir <= 1'b0;
            end
            if (pos_clr) begin
                r_pos <= '0;
            end else if (w_step_up) begin
                r_pos <= r_pos + CNTW'(1);
            end else if (w_step_dn) begin
                r_pos <= r_pos - CNTW'(1);
            end
            if (w_err && r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign b       = r_p;
    assign b_valid = r_b_valid;
    assign step_up = r_step_up;
    assign step_dn = r_step_dn;
    assign err     = r_err;
    assign dir     = r_dir;
    assign pos     = r_pos;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_gray_to_bin_tracker.sv
// Directed bench for gray_to_bin_tracker; works in both the default and GRAY_SYNC_EN builds.
module tb_gray_to_bin_tracker;

`ifdef GRAY_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [3:0] g = 4'h0;
    logic       pos_clr = 1'b0;
    logic [3:0] b;
    logic       b_valid;
    logic       step_up;
    logic       step_dn;
    logic       err;
    logic       dir;
    logic [7:0] pos;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_fail = 0;

    gray_to_bin_tracker #(.W(4), .CNTW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .g       (g),
        .pos_clr (pos_clr),
        .b       (b),
        .b_valid (b_valid),
        .step_up (step_up),
        .step_dn (step_dn),
        .err     (err),
        .dir     (dir),
        .pos     (pos),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One enabled capture of gv; idle cycles let the synchronizer fill first.
    task automatic sample(input logic [3:0] gv, input logic clr);
        g = gv;
        en = 1'b0;
        pos_clr = 1'b0;
        repeat (SYNC) tick();
        en = 1'b1;
        pos_clr = clr;
        tick();
        en = 1'b0;
        pos_clr = 1'b0;
        $display("sample g=%h clr=%b -> b=%h v=%b up=%b dn=%b err=%b dir=%b pos=%0d err_cnt=%0d",
                 gv, clr, b, b_valid, step_up, step_dn, err, dir, pos, err_cnt);
    endtask

    task automatic test_reset();
        en = 1'b1;
        g = 4'h5;
        pos_clr = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en = 1'b0;
        pos_clr = 1'b0;
        $display("reset -> b=%h v=%b pos=%0d err_cnt=%0d", b, b_valid, pos, err_cnt);
        n_checks++;
        if ({b, b_valid, step_up, step_dn, err, dir} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got b=%h v=%b up=%b dn=%b err=%b dir=%b, want all 0",
                     b, b_valid, step_up, step_dn, err, dir);
        end
        n_checks++;
        if (pos !== 8'd0 || err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_counts: got pos=%0d err_cnt=%0d, want 0 0", pos, err_cnt);
        end
    endtask

    task automatic test_basic();
        logic [3:0] seq [4];
        seq = '{4'h0, 4'h1, 4'h3, 4'h2};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sample(seq[i], 1'b0);
            n_checks++;
            if (b !== 4'(i) || b_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_b[%0d]: got b=%h v=%b, want b=%h v=1", i, b, b_valid, 4'(i));
            end
            n_checks++;
            if (step_up !== (i > 0) || step_dn !== 1'b0 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_pulse[%0d]: got up=%b dn=%b err=%b, want up=%b dn=0 err=0",
                         i, step_up, step_dn, err, (i > 0));
            end
        end
        n_checks++;
        if (pos !== 8'd3 || dir !== 1'b1 || err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL basic_end: got pos=%0d dir=%b err_cnt=%0d, want 3 1 0", pos, dir, err_cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        sample(4'h8, 1'b0);
        n_checks++;
        if (b !== 4'hF || step_up !== 1'b0 || step_dn !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_prime: got b=%h up=%b dn=%b err=%b, want b=f no pulse", b, step_up, step_dn, err);
        end
        sample(4'h0, 1'b0);
        n_checks++;
        if (b !== 4'h0 || step_up !== 1'b1 || pos !== 8'd1 || dir !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_up: got b=%h up=%b pos=%0d dir=%b, want b=0 up=1 pos=1 dir=1", b, step_up, pos, dir);
        end
        sample(4'h8, 1'b0);
        n_checks++;
        if (b !== 4'hF || step_dn !== 1'b1 || step_up !== 1'b0 || pos !== 8'd0 || dir !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_dn: got b=%h dn=%b up=%b pos=%0d dir=%b, want b=f dn=1 up=0 pos=0 dir=0",
                     b, step_dn, step_up, pos, dir);
        end
        sample(4'h8, 1'b0);
        sample(4'h9, 1'b0);
        n_checks++;
        if (b !== 4'hE || step_dn !== 1'b1 || pos !== 8'd255) begin
            n_fail++;
            $display("FAIL pos_wrap_dn: got b=%h dn=%b pos=%0d, want b=e dn=1 pos=255", b, step_dn, pos);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        sample(4'h3, 1'b0);
        sample(4'h6, 1'b0);
        n_checks++;
        if (b !== 4'h4 || err !== 1'b1 || step_up !== 1'b0 || step_dn !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_err: got b=%h err=%b up=%b dn=%b, want b=4 err=1 up=0 dn=0", b, err, step_up, step_dn);
        end
        n_checks++;
        if (err_cnt !== 8'd1 || pos !== 8'd0 || dir !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_cnt: got err_cnt=%0d pos=%0d dir=%b, want 1 0 0", err_cnt, pos, dir);
        end
        sample(4'h7, 1'b0);
        n_checks++;
        if (b !== 4'h5 || step_up !== 1'b1 || err !== 1'b0 || pos !== 8'd1 || err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL illegal_resync: got b=%h up=%b err=%b pos=%0d err_cnt=%0d, want 5 1 0 1 1",
                     b, step_up, err, pos, err_cnt);
        end
    endtask

    task automatic test_saturate();
        int n_err_seen;
        n_err_seen = 0;
        do_reset();
        sample(4'h0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            sample((i % 2 == 0) ? 4'hC : 4'h0, 1'b0);
            if (err === 1'b1) n_err_seen++;
            if (i == 253) begin
                n_checks++;
                if (err_cnt !== 8'd254) begin
                    n_fail++;
                    $display("FAIL sat_mid: got err_cnt=%0d, want 254", err_cnt);
                end
            end
        end
        n_checks++;
        if (err_cnt !== 8'd255 || n_err_seen != 300) begin
            n_fail++;
            $display("FAIL sat_end: got err_cnt=%0d err_pulses=%0d, want 255 300", err_cnt, n_err_seen);
        end
        n_checks++;
        if (pos !== 8'd0) begin
            n_fail++;
            $display("FAIL sat_pos: got pos=%0d, want 0", pos);
        end
    endtask

    task automatic test_clear_and_hold();
        logic [3:0] up_seq [5];
        up_seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7};
        do_reset();
        sample(4'h0, 1'b0);
        for (int i = 0; i < 5; i++) sample(up_seq[i], 1'b0);
        n_checks++;
        if (pos !== 8'd5) begin
            n_fail++;
            $display("FAIL clr_pre: got pos=%0d, want 5", pos);
        end
        sample(4'h5, 1'b1);
        n_checks++;
        if (pos !== 8'd0 || step_up !== 1'b1 || dir !== 1'b1 || b !== 4'h6) begin
            n_fail++;
            $display("FAIL clr_step: got pos=%0d up=%b dir=%b b=%h, want 0 1 1 6", pos, step_up, dir, b);
        end
        for (int i = 0; i < 4; i++) begin
            en = 1'b0;
            g = (i % 2 == 0) ? 4'h4 : 4'hA;
            tick();
            $display("idle g=%h -> b=%h up=%b dn=%b err=%b pos=%0d", g, b, step_up, step_dn, err, pos);
            n_checks++;
            if (b !== 4'h6 || step_up !== 1'b0 || step_dn !== 1'b0 || err !== 1'b0 || pos !== 8'd0) begin
                n_fail++;
                $display("FAIL hold[%0d]: got b=%h up=%b dn=%b err=%b pos=%0d, want b=6 no pulse pos=0",
                         i, b, step_up, step_dn, err, pos);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] up_seq [7];
        up_seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4};
        do_reset();
        sample(4'h0, 1'b0);
        for (int i = 0; i < 7; i++) sample(up_seq[i], 1'b0);
        n_checks++;
        if (pos !== 8'd7 || b !== 4'h7) begin
            n_fail++;
            $display("FAIL mid_pre: got pos=%0d b=%h, want 7 7", pos, b);
        end
        do_reset();
        $display("mid reset -> b=%h v=%b up=%b dir=%b pos=%0d", b, b_valid, step_up, dir, pos);
        n_checks++;
        if ({b, b_valid, step_up, step_dn, err, dir} !== 9'b0 || pos !== 8'd0 || err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got b=%h v=%b up=%b dir=%b pos=%0d, want all 0", b, b_valid, step_up, dir, pos);
        end
        sample(4'h5, 1'b0);
        n_checks++;
        if (b !== 4'h6 || b_valid !== 1'b1 || step_up !== 1'b0 || step_dn !== 1'b0 || err !== 1'b0 || pos !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reprime: got b=%h v=%b up=%b dn=%b err=%b pos=%0d, want b=6 v=1 no pulse pos=0",
                     b, b_valid, step_up, step_dn, err, pos);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_illegal();
        test_saturate();
        test_clear_and_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
